matrix_io_sequencer: RTL and testbench

MATRIX_IO_SEQUENCER -- requirements
Module: matrix_io_sequencer

---
 rtl/matrix_io_pkg.sv | 14 +
 rtl/matrix_byte_packer.sv | 24 ++
 rtl/matrix_io_sequencer.sv | 108 ++++++++++
 tb/tb_matrix_io_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_io_pkg.sv
// Shared types and sizes for the matrix I/O sequencer.
package matrix_io_pkg;

  localparam int unsigned BYTES_PER_MATRIX = 8;
  localparam int unsigned MATRIX_BITS      = 64;

  typedef enum logic [1:0] {
    StLoadA,
    StLoadB,
    StWait,
    StDrain
  } seq_state_t;

endpackage

// File: rtl/matrix_byte_packer.sv
// Eight-byte MSB-first shift register with load enable and a 3-bit byte count.
module matrix_byte_packer
  import matrix_io_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [7:0]             byte_in,
  output logic [MATRIX_BITS-1:0] word,
  output logic [2:0]             count
);

  // Count wraps 7->0 on the eighth byte, which is exactly the phase boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word  <= '0;
      count <= '0;
    end else if (load_en) begin
      word  <= {word[MATRIX_BITS-9:0], byte_in};
      count <= count + 3'd1;
    end
  end

endmodule

// File: rtl/matrix_io_sequencer.sv
// Streams two 8-byte operands into a multiply unit, waits a fixed latency for
// the result, then streams the 8 result bytes back out.
module matrix_io_sequencer
  import matrix_io_pkg::*;
#(
  parameter int unsigned CAPTURE_DELAY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [MATRIX_BITS-1:0] matrix_a,
  output logic [MATRIX_BITS-1:0] matrix_b,
  output logic                   mat_start,
  input  logic [MATRIX_BITS-1:0] mmu_result,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   frame_done
);

  seq_state_t state_q, state_d;

  logic                   a_load, b_load, a_last, b_last;
  logic [MATRIX_BITS-1:0] a_word, b_word;
  logic [2:0]             a_count, b_count;
  logic [3:0]             wait_count_q;
  logic [2:0]             out_count_q;
  logic [MATRIX_BITS-1:0] out_sr_q;
  logic                   capture, out_xfer;

  assign in_ready   = (state_q == StLoadA) || (state_q == StLoadB);
  assign a_load     = in_valid && (state_q == StLoadA);
  assign b_load     = in_valid && (state_q == StLoadB);
  assign a_last     = a_load && (a_count == 3'd7);
  assign b_last     = b_load && (b_count == 3'd7);
  assign capture    = (state_q == StWait) && (wait_count_q == 4'(CAPTURE_DELAY - 1));
  assign out_valid  = (state_q == StDrain);
  assign out_xfer   = out_valid && out_ready;
  assign out_data   = out_sr_q[MATRIX_BITS-1 -: 8];
  assign frame_done = out_xfer && (out_count_q == 3'd7);
  assign busy       = !((state_q == StLoadA) && (a_count == 3'd0));

  matrix_byte_packer u_pack_a (
    .clk     (clk),
    .rst     (rst),
    .load_en (a_load),
    .byte_in (in_data),
    .word    (a_word),
    .count   (a_count)
  );

  matrix_byte_packer u_pack_b (
    .clk     (clk),
    .rst     (rst),
    .load_en (b_load),
    .byte_in (in_data),
    .word    (b_word),
    .count   (b_count)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoadA: if (a_last)     state_d = StLoadB;
      StLoadB: if (b_last)     state_d = StWait;
      StWait:  if (capture)    state_d = StDrain;
      StDrain: if (frame_done) state_d = StLoadA;
      default:                 state_d = StLoadA;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StLoadA;
      matrix_a     <= '0;
      matrix_b     <= '0;
      mat_start    <= 1'b0;
      wait_count_q <= '0;
      out_sr_q     <= '0;
      out_count_q  <= '0;
    end else begin
      state_q   <= state_d;
      mat_start <= b_last;
      // B's last byte is still on in_data, so splice it in rather than wait a cycle.
      if (b_last) begin
        matrix_a <= a_word;
        matrix_b <= {b_word[MATRIX_BITS-9:0], in_data};
      end
      if (state_q != StWait) begin
        wait_count_q <= '0;
      end else if (!capture) begin
        wait_count_q <= wait_count_q + 4'd1;
      end
      if (capture) begin
        out_sr_q <= mmu_result;
      end else if (out_xfer) begin
        out_sr_q <= {out_sr_q[MATRIX_BITS-9:0], 8'h00};
      end
      if (out_xfer) begin
        out_count_q <= out_count_q + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_matrix_io_sequencer.sv
// Scoreboard bench: three sequencers (capture delay 3, 1, 15) share one stimulus stream.
module tb_matrix_io_sequencer;

  localparam int N = 3;
  localparam logic [63:0] CONST_RES = 64'hFEDCBA9876543210;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;
  logic        mode;
  logic [63:0] mmu;
  int          cyc = 0;

  logic        in_ready_w   [N];
  logic [63:0] mat_a_w      [N];
  logic [63:0] mat_b_w      [N];
  logic        mat_start_w  [N];
  logic [7:0]  out_data_w   [N];
  logic        out_valid_w  [N];
  logic        busy_w       [N];
  logic        frame_done_w [N];

  int total = 0;
  int bad   = 0;

  logic [7:0]  q0[$], q1[$], q2[$];
  logic [63:0] exp_a[$], exp_b[$];
  logic [63:0] cur_a, cur_b;
  logic [63:0] hold_a [N];
  logic [63:0] hold_b [N];
  int          xfer [N];
  logic        prev_start [N];
  logic        prev_done [N];
  logic        prev_stall;
  logic [7:0]  prev_data;
  logic        chk_rst, chk_end;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mmu_at(int k);
    logic [7:0] kb;
    kb = k[7:0];
    return 64'h0123456789ABCDEF ^ {8{kb}};
  endfunction

  function automatic int dly(int i);
    case (i)
      0:       return 3;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  // Time-varying result in mode 1 exposes any off-by-one in the capture point.
  assign mmu = mode ? mmu_at(cyc) : CONST_RES;

  for (genvar g = 0; g < N; g++) begin : g_dut
    matrix_io_sequencer #(
      .CAPTURE_DELAY ((g == 0) ? 3 : (g == 1) ? 1 : 15)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready_w[g]),
      .matrix_a   (mat_a_w[g]),
      .matrix_b   (mat_b_w[g]),
      .mat_start  (mat_start_w[g]),
      .mmu_result (mmu),
      .out_data   (out_data_w[g]),
      .out_valid  (out_valid_w[g]),
      .out_ready  (out_ready),
      .busy       (busy_w[g]),
      .frame_done (frame_done_w[g])
    );
  end

  function automatic void push_exp(int i, logic [63:0] w);
    for (int j = 0; j < 8; j++) begin
      case (i)
        0:       q0.push_back(w[63-8*j -: 8]);
        1:       q1.push_back(w[63-8*j -: 8]);
        default: q2.push_back(w[63-8*j -: 8]);
      endcase
    end
  endfunction

  function automatic int qsize(int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] qpop(int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(input string name, input int i, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h expected %h at t=%0t", name, i, act, exp, $time);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (chk_rst) begin
      for (int i = 0; i < N; i++) begin
        chk("rst_matrix_a", i, mat_a_w[i], 64'h0);
        chk("rst_matrix_b", i, mat_b_w[i], 64'h0);
        chk("rst_out_data", i, {56'h0, out_data_w[i]}, 64'h0);
        chk("rst_flags", i, {60'h0, mat_start_w[i], out_valid_w[i], frame_done_w[i],
                             busy_w[i]}, 64'h0);
        chk("rst_in_ready", i, {63'h0, in_ready_w[i]}, 64'h1);
      end
    end
    if (chk_end) begin
      for (int i = 0; i < N; i++) chk("leftover_results", i, qsize(i), 0);
      chk("leftover_frames", 0, exp_a.size(), 0);
    end
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        xfer[i] = 0; prev_start[i] = 1'b0; prev_done[i] = 1'b0;
        hold_a[i] = '0; hold_b[i] = '0;
      end
      prev_stall = 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (mat_start_w[i]) begin
          if (i == 0) begin
            if (exp_a.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_mat_start dut0: got pulse expected none");
            end else begin
              cur_a = exp_a.pop_front();
              cur_b = exp_b.pop_front();
            end
          end
          chk("matrix_a", i, mat_a_w[i], cur_a);
          chk("matrix_b", i, mat_b_w[i], cur_b);
          push_exp(i, mode ? mmu_at(cyc + dly(i) - 1) : CONST_RES);
          hold_a[i] = mat_a_w[i];
          hold_b[i] = mat_b_w[i];
        end else begin
          chk("matrix_a_hold", i, mat_a_w[i], hold_a[i]);
          chk("matrix_b_hold", i, mat_b_w[i], hold_b[i]);
        end
        if (prev_start[i]) chk("mat_start_pulse", i, {63'h0, mat_start_w[i]}, 64'h0);
        if (prev_done[i]) begin
          chk("in_ready_after_done", i, {63'h0, in_ready_w[i]}, 64'h1);
          chk("busy_after_done", i, {63'h0, busy_w[i]}, 64'h0);
        end
        if (i == 0 && prev_stall) chk("stall_hold", 0, {56'h0, out_data_w[0]},
                                      {56'h0, prev_data});
        if (out_valid_w[i] && out_ready) begin
          if (qsize(i) == 0) begin
            total++; bad++;
            $display("FAIL unexpected_byte dut%0d: got %h expected none", i, out_data_w[i]);
          end else begin
            chk("out_data", i, {56'h0, out_data_w[i]}, {56'h0, qpop(i)});
          end
          chk("frame_done", i, {63'h0, frame_done_w[i]}, {63'h0, xfer[i] == 7});
          xfer[i] = (xfer[i] + 1) % 8;
        end else begin
          chk("frame_done_idle", i, {63'h0, frame_done_w[i]}, 64'h0);
        end
        prev_start[i] = mat_start_w[i];
        prev_done[i]  = frame_done_w[i];
      end
      prev_stall = out_valid_w[0] && !out_ready;
      prev_data  = out_data_w[0];
    end
  end

  function automatic logic all_ready();
    return in_ready_w[0] && in_ready_w[1] && in_ready_w[2];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    repeat ($urandom_range(0, 2)) @(posedge clk);
    n = 0;
    @(negedge clk);
    while (!all_ready()) begin
      n++;
      if (n > 200) begin
        $display("FAIL in_ready_timeout: got in_ready low expected high within 200 cycles");
        $fatal(1, "in_ready timeout");
      end
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] a, input logic [63:0] b, input bit extra);
    exp_a.push_back(a);
    exp_b.push_back(b);
    for (int j = 0; j < 8; j++) send_byte(a[63-8*j -: 8]);
    for (int j = 0; j < 8; j++) send_byte(b[63-8*j -: 8]);
    if (extra) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    chk_rst = 1'b1;
    @(negedge clk);
    #1 chk_rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; mode = 1'b0;
    chk_rst = 1'b0; chk_end = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_rst = 1'b1;
    @(negedge clk);
    #1 chk_rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    send_frame(64'h0123456789ABCDEF, 64'h1011121314151617, 1'b0);
    mode = 1'b1;
    send_frame(64'hA0B1C2D3E4F50617, 64'hFFEEDDCCBBAA9988, 1'b1);
    send_frame(64'h1122334455667788, 64'h8877665544332211, 1'b0);
    n = 0;
    while (!out_valid_w[0]) begin
      @(posedge clk);
      n++;
      if (n > 100) begin
        $display("FAIL drain_timeout: got out_valid low expected high within 100 cycles");
        $fatal(1, "drain timeout");
      end
    end
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;

    // Abandoned frame: reset lands after the fourth B byte.
    for (int j = 0; j < 8; j++) send_byte(8'h55);
    for (int j = 0; j < 4; j++) send_byte(8'h66);
    pulse_reset();
    send_frame(64'hDEADBEEFCAFEF00D, 64'h0F1E2D3C4B5A6978, 1'b0);
    mode = 1'b0;
    send_frame(64'hF0E1D2C3B4A59687, 64'h0011223344556677, 1'b0);

    n = 0;
    @(negedge clk);
    while (busy_w[0] || busy_w[1] || busy_w[2]) begin
      n++;
      if (n > 300) begin
        $display("FAIL idle_timeout: got busy high expected low within 300 cycles");
        $fatal(1, "idle timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1 chk_end = 1'b1;
    @(negedge clk);
    #1 chk_end = 1'b0;
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500us");
    $fatal(1, "global timeout");
  end

endmodule
